// File: rtl/sub_pkg.sv
// Shared widths and the first-stage record for the two-stage 8-bit subtractor.
package sub_pkg;

  localparam int NIBBLE_W = 4;
  localparam int DATA_W   = 8;

  // Stage 1 keeps the finished low nibble plus the raw upper operands for stage 2.
  typedef struct packed {
    logic                valid;
    logic [NIBBLE_W-1:0] dlo;
    logic                blo;
    logic [NIBBLE_W-1:0] ahi;
    logic [NIBBLE_W-1:0] bhi;
  } stage1_t;

endpackage

// File: rtl/bla_4.sv
// 4-bit borrow-lookahead subtractor: d = a - b - bin, all borrows formed in parallel.
module bla_4
  import sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic                bout
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  // A bit borrows when a=0,b=1 and passes an incoming borrow through when a==b.
  assign p = ~(a ^ b);
  assign g = ~a & b;

  assign c[0] = bin;
  assign c[1] = g[0] | (p[0] & bin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d    = a ^ b ^ c[NIBBLE_W-1:0];
  assign bout = c[NIBBLE_W];

endmodule

// File: rtl/sub_pipe_8.sv
// Two-stage valid/ready 8-bit subtractor (low nibble in S1, high nibble in S2).
// Define SUB_PIPE_8_SAT_EN to clamp underflowing results to zero.
module sub_pipe_8
  import sub_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] d,
  output logic              bout
);

  stage1_t             s1;
  logic                s2_valid;
  logic [DATA_W-1:0]   s2_d;
  logic                s2_bout;

  logic [NIBBLE_W-1:0] lo_d;
  logic                lo_b;
  logic [NIBBLE_W-1:0] hi_d;
  logic                hi_b;
  logic [DATA_W-1:0]   res_d;
  logic                s2_load;

  bla_4 u_lo (
    .a    (a[NIBBLE_W-1:0]),
    .b    (b[NIBBLE_W-1:0]),
    .bin  (bin),
    .d    (lo_d),
    .bout (lo_b)
  );

  bla_4 u_hi (
    .a    (s1.ahi),
    .b    (s1.bhi),
    .bin  (s1.blo),
    .d    (hi_d),
    .bout (hi_b)
  );

  // S2 frees up when empty or being drained; S1 can then always move forward.
  assign s2_load  = ~s2_valid | out_ready;
  assign in_ready = ~s1.valid | s2_load;

`ifdef SUB_PIPE_8_SAT_EN
  assign res_d = hi_b ? '0 : {hi_d, s1.dlo};
`else
  assign res_d = {hi_d, s1.dlo};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2_valid <= 1'b0;
      s2_d     <= '0;
      s2_bout  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1.valid <= in_valid;
        if (in_valid) begin
          s1.dlo <= lo_d;
          s1.blo <= lo_b;
          s1.ahi <= a[DATA_W-1:NIBBLE_W];
          s1.bhi <= b[DATA_W-1:NIBBLE_W];
        end
      end
      // Data only moves with a valid record so d keeps its last real value.
      if (s2_load) begin
        s2_valid <= s1.valid;
        if (s1.valid) begin
          s2_d    <= res_d;
          s2_bout <= hi_b;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign d         = s2_d;
  assign bout      = s2_bout;

endmodule

// File: tb/tb_sub_pipe_8.sv
// Self-checking bench for sub_pipe_8: directed table, backpressure, reset and random stream.
module tb_sub_pipe_8;

`ifdef SUB_PIPE_8_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic       bout;

  always #5 clk = ~clk;

  sub_pipe_8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] expD;
    logic       expBout;
  } vec_t;

  int         testsRun = 0;
  int         testsFailed = 0;
  logic [8:0] sbQ[$];
  bit         monitorOn = 1'b0;
  bit         lastAccepted;
  int         resultsSeen;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [8:0] refModel(input logic [7:0] x, input logic [7:0] y,
                                          input logic bi);
    logic [8:0] r;
    r = {1'b0, x} - {1'b0, y} - {8'b0, bi};
    if (SAT && r[8]) r[7:0] = 8'h00;
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                               input logic bi);
    in_valid = v;
    a        = aa;
    b        = bb;
    bin      = bi;
  endtask

  // One clock: scoreboard both handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    logic [8:0] exp;
    @(negedge clk);
    lastAccepted = in_valid && in_ready;
    if (monitorOn) begin
      if (lastAccepted) sbQ.push_back(refModel(a, b, bin));
      if (out_valid && out_ready) begin
        resultsSeen++;
        if (sbQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL spurious_result: got 0x%0h, expected no result", {bout, d});
        end else begin
          exp = sbQ.pop_front();
          checkOutput("stream_result", 32'({bout, d}), 32'(exp));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t       vecs[12];
    vec_t       pairs[4];
    int         idx;
    int         cyc;
    int         sent;
    logic [8:0] held;
    logic [7:0] uf;

    uf = SAT ? 8'h00 : 8'hFF;
    vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1]  = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    vecs[2]  = '{8'h00, 8'h00, 1'b1, uf,    1'b1};
    vecs[3]  = '{8'h00, 8'h01, 1'b0, uf,    1'b1};
    vecs[4]  = '{8'hFF, 8'hFF, 1'b1, uf,    1'b1};
    vecs[5]  = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[6]  = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    vecs[7]  = '{8'h7F, 8'h80, 1'b0, SAT ? 8'h00 : 8'hFF, 1'b1};
    vecs[8]  = '{8'h34, 8'h12, 1'b1, 8'h21, 1'b0};
    vecs[9]  = '{8'h0F, 8'h0F, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[11] = '{8'hA0, 8'h0A, 1'b0, 8'h96, 1'b0};

    pairs[0] = '{8'h11, 8'h22, 1'b0, 8'h00, 1'b0};
    pairs[1] = '{8'h99, 8'h09, 1'b1, 8'h00, 1'b0};
    pairs[2] = '{8'h40, 8'h41, 1'b0, 8'h00, 1'b0};
    pairs[3] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b0};

    rst = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_d", 32'(d), 32'h00);
    checkOutput("reset_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed table: one pair at a time, result expected exactly two edges later.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_not_early", i), 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_d", i), 32'(d), 32'(vecs[i].expD));
      checkOutput($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].expBout));
    end
    @(posedge clk);
    #1;
    checkOutput("table_drained", 32'(out_valid), 32'd0);

    // Backpressure: only two pairs fit, output holds, then everything drains in order.
    monitorOn = 1'b1;
    sbQ.delete();
    resultsSeen = 0;
    out_ready = 1'b0;
    idx = 0;
    held = '0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, pairs[idx].a, pairs[idx].b, pairs[idx].bin);
      tick();
      if (lastAccepted) idx++;
      if (c == 2) held = {bout, d};
    end
    checkOutput("bp_accepted", 32'(idx), 32'd2);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_hold_stable", 32'({bout, d}), 32'(held));
    checkOutput("bp_first_result", 32'({bout, d}),
                32'(refModel(pairs[0].a, pairs[0].b, pairs[0].bin)));
    out_ready = 1'b1;
    cyc = 0;
    while ((idx < 4 || sbQ.size() != 0) && cyc < 20) begin
      if (idx < 4) applyStimulus(1'b1, pairs[idx].a, pairs[idx].b, pairs[idx].bin);
      else         applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      if (lastAccepted) idx++;
      cyc++;
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("bp_results_seen", 32'(resultsSeen), 32'd4);
    checkOutput("bp_queue_empty", 32'(sbQ.size()), 32'd0);

    // Reset with both stages full and a handshake on the same edge.
    monitorOn = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h77, 8'h11, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h66, 8'h22, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rstmid_full_valid", 32'(out_valid), 32'd1);
    checkOutput("rstmid_full_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h55, 8'h33, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rstmid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rstmid_d", 32'(d), 32'h00);
    checkOutput("rstmid_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("rstmid_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rstmid_no_stale%0d", c), 32'(out_valid), 32'd0);
    end

    // Random stream against the arithmetic reference model with random backpressure.
    monitorOn = 1'b1;
    sbQ.delete();
    resultsSeen = 0;
    sent = 0;
    cyc = 0;
    while ((sent < 2000 || sbQ.size() != 0) && cyc < 20000) begin
      applyStimulus(sent < 2000 && $urandom_range(0, 3) != 0, 8'($urandom),
                    8'($urandom), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (lastAccepted) sent++;
      cyc++;
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("random_sent", 32'(sent), 32'd2000);
    checkOutput("random_results", 32'(resultsSeen), 32'd2000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
